// File: rtl/i2c_slave_single_byte.sv
// I2C bus target: synchronises SCL/SDA, decodes START/STOP, matches a 7-bit address and
// moves one data byte to (write) or from (read) the fabric. SDA is driven open-drain only.
module i2c_slave_single_byte #(
   parameter logic [6:0] SLAVE_ADDR = 7'b1010110
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_enable,
   input  logic [7:0] i_tx_byte,
   output logic [7:0] o_rx_byte,
   output logic       o_rx_valid,
   output logic       o_tx_req,
   output logic       o_busy,
   output logic       o_error,
   inout  wire        io_scl,
   inout  wire        io_sda
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP
   } state_t;

   state_t     state, state_nx;
   logic [2:0] cnt, cnt_nx;
   logic       step, step_nx;
   logic       sda_low, sda_low_nx;
   logic [7:0] rx_byte_nx;
   logic       rx_valid_nx, tx_req_nx, busy_nx, error_nx;
   logic [7:0] shift, shift_nx;
   logic [7:0] tx_shift, tx_shift_nx;
   logic       rw, rw_nx;
   logic [7:0] new_byte;
   logic       scl_p0, scl_p1, scl_p2;
   logic       sda_p0, sda_p1, sda_p2;
   logic       scl_rise, scl_fall, start, stop, mid_byte, addr_hit;

   // Stage p0/p1: two-flop synchroniser; p2: previous value for edge detection
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         scl_p0 <= 1'b1;
         scl_p1 <= 1'b1;
         scl_p2 <= 1'b1;
         sda_p0 <= 1'b1;
         sda_p1 <= 1'b1;
         sda_p2 <= 1'b1;
      end else begin
         scl_p0 <= io_scl;
         scl_p1 <= scl_p0;
         scl_p2 <= scl_p1;
         sda_p0 <= io_sda;
         sda_p1 <= sda_p0;
         sda_p2 <= sda_p1;
      end
   end

   assign scl_rise = scl_p1 & ~scl_p2;
   assign scl_fall = ~scl_p1 & scl_p2;
   assign start    = scl_p1 & scl_p2 & ~sda_p1 & sda_p2;
   assign stop     = scl_p1 & scl_p2 & sda_p1 & ~sda_p2;
   assign mid_byte = (((state == ADDR) || (state == RX_DATA) || (state == TX_DATA)) && (cnt != 3'd0))
                     || (state == ADDR_ACK) || (state == RX_ACK) || (state == TX_ACK);

   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt;
      step_nx     = step;
      sda_low_nx  = sda_low;
      rx_byte_nx  = o_rx_byte;
      rx_valid_nx = 1'b0;
      tx_req_nx   = 1'b0;
      busy_nx     = o_busy;
      error_nx    = 1'b0;
      shift_nx    = shift;
      tx_shift_nx = tx_shift;
      rw_nx       = rw;
      new_byte    = {shift[6:0], sda_p1};
      addr_hit    = (new_byte[7:1] == SLAVE_ADDR) && (new_byte[7:1] != 7'd0);
      if (!i_enable) begin
         state_nx   = IDLE;
         cnt_nx     = 3'd0;
         step_nx    = 1'b0;
         sda_low_nx = 1'b0;
         busy_nx    = 1'b0;
      end else if (start || stop) begin
         error_nx   = mid_byte;
         state_nx   = start ? ADDR : IDLE;
         cnt_nx     = 3'd0;
         step_nx    = 1'b0;
         sda_low_nx = 1'b0;
         busy_nx    = 1'b0;
      end else begin
         case (state)
            ADDR: begin
               if (scl_rise) begin
                  shift_nx = new_byte;
                  cnt_nx   = cnt + 3'd1;
                  if (cnt == 3'd7) begin
                     if (addr_hit) begin
                        state_nx = ADDR_ACK;
                        busy_nx  = 1'b1;
                        rw_nx    = new_byte[0];
                     end else begin
                        state_nx = WAIT_STOP;
                     end
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  if (!step) begin
                     sda_low_nx = 1'b1;
                     step_nx    = 1'b1;
                  end else begin
                     step_nx = 1'b0;
                     cnt_nx  = 3'd0;
                     if (!rw) begin
                        sda_low_nx = 1'b0;
                        state_nx   = RX_DATA;
                     end else begin
                        tx_req_nx   = 1'b1;
                        sda_low_nx  = ~i_tx_byte[7];
                        tx_shift_nx = {i_tx_byte[6:0], 1'b0};
                        state_nx    = TX_DATA;
                     end
                  end
               end
            end
            RX_DATA: begin
               if (scl_rise) begin
                  shift_nx = new_byte;
                  cnt_nx   = cnt + 3'd1;
                  if (cnt == 3'd7) state_nx = RX_ACK;
               end
            end
            RX_ACK: begin
               if (scl_fall) begin
                  if (!step) begin
                     sda_low_nx  = 1'b1;
                     rx_byte_nx  = shift;
                     rx_valid_nx = 1'b1;
                     step_nx     = 1'b1;
                  end else begin
                     sda_low_nx = 1'b0;
                     step_nx    = 1'b0;
                     state_nx   = WAIT_STOP;
                  end
               end
            end
            TX_DATA: begin
               // step marks that all eight bits have been clocked out
               if (scl_rise) begin
                  cnt_nx = cnt + 3'd1;
                  if (cnt == 3'd7) step_nx = 1'b1;
               end else if (scl_fall) begin
                  if (step) begin
                     sda_low_nx = 1'b0;
                     step_nx    = 1'b0;
                     state_nx   = TX_ACK;
                  end else begin
                     sda_low_nx  = ~tx_shift[7];
                     tx_shift_nx = {tx_shift[6:0], 1'b0};
                  end
               end
            end
            TX_ACK: begin
               if (scl_rise) state_nx = WAIT_STOP;
            end
            default: begin
            end
         endcase
      end
   end

   // Stage p3: control state and outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         cnt        <= 3'd0;
         step       <= 1'b0;
         sda_low    <= 1'b0;
         o_rx_byte  <= 8'h00;
         o_rx_valid <= 1'b0;
         o_tx_req   <= 1'b0;
         o_busy     <= 1'b0;
         o_error    <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         step       <= step_nx;
         sda_low    <= sda_low_nx;
         o_rx_byte  <= rx_byte_nx;
         o_rx_valid <= rx_valid_nx;
         o_tx_req   <= tx_req_nx;
         o_busy     <= busy_nx;
         o_error    <= error_nx;
      end
   end

   always_ff @(posedge i_clk) begin
      shift    <= shift_nx;
      tx_shift <= tx_shift_nx;
      rw       <= rw_nx;
   end

   assign io_sda = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_slave_single_byte.sv
// Directed bench for i2c_slave_single_byte: a bit-banged open-drain master plus a vector
// table of whole transactions and hand-written abort, enable and reset sequences.
`timescale 1ns/1ps
module tb_i2c_slave_single_byte;

   localparam time Q = 100;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic [7:0] tx_byte;
   logic [7:0] rx_byte;
   logic       rx_valid, tx_req, busy, error;
   logic       m_scl_low = 1'b0;
   logic       m_sda_low = 1'b0;
   wire        scl, sda;

   pullup (scl);
   pullup (sda);
   assign scl = m_scl_low ? 1'b0 : 1'bz;
   assign sda = m_sda_low ? 1'b0 : 1'bz;

   i2c_slave_single_byte #(.SLAVE_ADDR(7'b1010110)) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_enable  (enable),
      .i_tx_byte (tx_byte),
      .o_rx_byte (rx_byte),
      .o_rx_valid(rx_valid),
      .o_tx_req  (tx_req),
      .o_busy    (busy),
      .o_error   (error),
      .io_scl    (scl),
      .io_sda    (sda)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int rxv_cnt = 0;
   int txr_cnt = 0;
   int err_cnt = 0;

   always @(negedge clk) begin
      if (rx_valid) rxv_cnt++;
      if (tx_req)   txr_cnt++;
      if (error)    err_cnt++;
   end

   initial begin
      #(5_000_000);
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic align();
      @(posedge clk);
      #2;
   endtask

   task automatic clk_bit(input logic b, output logic s);
      m_sda_low = !b;
      #Q;
      m_scl_low = 1'b0;
      #Q;
      s = sda;
      #Q;
      m_scl_low = 1'b1;
      #Q;
   endtask

   task automatic start_c();
      m_sda_low = 1'b1;
      #Q;
      m_scl_low = 1'b1;
      #Q;
   endtask

   task automatic restart_c();
      m_sda_low = 1'b0;
      #Q;
      m_scl_low = 1'b0;
      #Q;
      start_c();
   endtask

   task automatic stop_c(input string name);
      m_sda_low = 1'b1;
      #Q;
      m_scl_low = 1'b0;
      #Q;
      m_sda_low = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check({name, " busy_after_stop"}, busy, 1'b0);
      #Q;
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
      clk_bit(1'b1, ack);
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] r, output logic slot);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1, s);
         r[i] = s;
      end
      clk_bit(mack, slot);
   endtask

   typedef struct {
      logic [6:0] addr;
      logic       rw;
      logic [7:0] data;
      logic       acked;
      logic [7:0] exp_rx;
      int         exp_valid;
      int         exp_req;
   } vec_t;

   vec_t vecs[7];

   initial begin
      logic       a, slot;
      logic [7:0] r;
      int         v0, t0, e0;
      vec_t       v;

      vecs[0] = '{7'h56, 1'b0, 8'h3C, 1'b1, 8'h3C, 1, 0};
      vecs[1] = '{7'h56, 1'b1, 8'hA5, 1'b1, 8'h3C, 0, 1};
      vecs[2] = '{7'h55, 1'b0, 8'h99, 1'b0, 8'h3C, 0, 0};
      vecs[3] = '{7'h00, 1'b0, 8'h99, 1'b0, 8'h3C, 0, 0};
      vecs[4] = '{7'h56, 1'b0, 8'h00, 1'b1, 8'h00, 1, 0};
      vecs[5] = '{7'h56, 1'b1, 8'h5A, 1'b1, 8'h00, 0, 1};
      vecs[6] = '{7'h56, 1'b0, 8'hFF, 1'b1, 8'hFF, 1, 0};

      rst_n   = 1'b0;
      enable  = 1'b1;
      tx_byte = 8'h00;
      #23;
      check("reset rx_byte", rx_byte, 8'h00);
      check("reset rx_valid", rx_valid, 1'b0);
      check("reset tx_req", tx_req, 1'b0);
      check("reset busy", busy, 1'b0);
      check("reset error", error, 1'b0);
      check("reset sda", sda, 1'b1);
      rst_n = 1'b1;
      #Q;

      for (int i = 0; i < 7; i++) begin
         v = vecs[i];
         tx_byte = v.data;
         align();
         v0 = rxv_cnt; t0 = txr_cnt; e0 = err_cnt;
         start_c();
         send_byte({v.addr, v.rw}, a);
         check($sformatf("v%0d addr_ack_sda", i), a, !v.acked);
         check($sformatf("v%0d busy", i), busy, v.acked);
         if (v.acked) begin
            if (!v.rw) begin
               send_byte(v.data, a);
               check($sformatf("v%0d data_ack_sda", i), a, 1'b0);
            end else begin
               read_byte(1'b1, r, slot);
               check($sformatf("v%0d read_bits", i), r, v.data);
               check($sformatf("v%0d ack_slot_sda", i), slot, 1'b1);
            end
         end
         stop_c($sformatf("v%0d", i));
         check($sformatf("v%0d rx_byte", i), rx_byte, v.exp_rx);
         check($sformatf("v%0d rx_valid_pulses", i), rxv_cnt - v0, v.exp_valid);
         check($sformatf("v%0d tx_req_pulses", i), txr_cnt - t0, v.exp_req);
         check($sformatf("v%0d error_pulses", i), err_cnt - e0, 0);
      end

      // Two data bytes: only the first is taken
      align();
      v0 = rxv_cnt;
      start_c();
      send_byte(8'hAC, a);
      check("two addr_ack", a, 1'b0);
      send_byte(8'h11, a);
      check("two first_ack", a, 1'b0);
      send_byte(8'h22, a);
      check("two second_nack", a, 1'b1);
      stop_c("two");
      check("two rx_byte", rx_byte, 8'h11);
      check("two rx_valid_pulses", rxv_cnt - v0, 1);

      // Repeated START after four data bits
      align();
      v0 = rxv_cnt; e0 = err_cnt;
      start_c();
      send_byte(8'hAC, a);
      check("abort addr_ack", a, 1'b0);
      clk_bit(1'b1, a);
      clk_bit(1'b0, a);
      clk_bit(1'b1, a);
      clk_bit(1'b0, a);
      restart_c();
      send_byte(8'hAC, a);
      check("abort readdr_ack", a, 1'b0);
      check("abort error_pulses", err_cnt - e0, 1);
      check("abort rx_byte_kept", rx_byte, 8'h11);
      check("abort rx_valid_none", rxv_cnt - v0, 0);
      send_byte(8'h77, a);
      check("abort data_ack", a, 1'b0);
      stop_c("abort");
      check("abort rx_byte_new", rx_byte, 8'h77);
      check("abort error_total", err_cnt - e0, 1);

      // Enable dropped while the address ACK is driven
      align();
      e0 = err_cnt;
      start_c();
      for (int i = 7; i >= 0; i--) begin
         logic [7:0] ab;
         ab = 8'hAC;
         clk_bit(ab[i], a);
      end
      m_sda_low = 1'b0;
      #Q;
      check("enable ack_driven", sda, 1'b0);
      check("enable busy_before", busy, 1'b1);
      enable = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("enable sda_released", sda, 1'b1);
      check("enable busy_cleared", busy, 1'b0);
      m_scl_low = 1'b0;
      #Q;
      m_scl_low = 1'b1;
      #Q;
      stop_c("enable");
      enable = 1'b1;
      check("enable no_error", err_cnt - e0, 0);

      // Reset asserted while the address ACK is driven
      align();
      start_c();
      for (int i = 7; i >= 0; i--) begin
         logic [7:0] ab;
         ab = 8'hAC;
         clk_bit(ab[i], a);
      end
      m_sda_low = 1'b0;
      #Q;
      check("rst ack_driven", sda, 1'b0);
      check("rst busy_before", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("rst sda_released", sda, 1'b1);
      check("rst rx_byte", rx_byte, 8'h00);
      check("rst busy", busy, 1'b0);
      check("rst rx_valid", rx_valid, 1'b0);
      check("rst tx_req", tx_req, 1'b0);
      check("rst error", error, 1'b0);
      m_scl_low = 1'b0;
      #Q;
      rst_n = 1'b1;
      #Q;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
